// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 6-stage IITB-RISC-23 pipeline.
// Drives per-register write enables and flushes, and expands LM/SM into micro-ops.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic       id_is_lmsm,
  input  logic [7:0] id_reglist,
  input  logic       redirect_id,
  input  logic       rf_ra_used,
  input  logic       rf_rb_used,
  input  logic [2:0] rf_ra,
  input  logic [2:0] rf_rb,
  input  logic       ex_mem_rd,
  input  logic [2:0] ex_rd,
  input  logic       redirect_ex,
  input  logic       ex_illegal,
  input  logic       dmem_stall,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       id_rf_we,
  output logic       rf_ex_we,
  output logic       ex_mem_we,
  output logic       mem_wb_we,
  output logic       if_id_flush,
  output logic       id_rf_flush,
  output logic       rf_ex_flush,
  output logic       ex_mem_flush,
  output logic       uop_valid,
  output logic [2:0] uop_reg,
  output logic       uop_first,
  output logic       uop_last,
  output logic       seq_busy,
  output logic       halted
);

  typedef enum logic [1:0] {RUN, MULTI, HALTED} state_t;

  state_t     state, state_nxt;
  logic [7:0] mask, mask_nxt;
  logic [7:0] sel;
  logic [7:0] rest;
  logic [2:0] low;
  logic       load_use;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  // The micro-op source is the live reglist on entry, the pending mask afterwards.
  assign sel  = (state == MULTI) ? mask : id_reglist;
  assign low  = lowest(sel);
  assign rest = sel & ~(8'd1 << low);

  assign load_use = ex_mem_rd && ((rf_ra_used && (rf_ra == ex_rd)) ||
                                  (rf_rb_used && (rf_rb == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      mask  <= 8'd0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mask_nxt     = mask;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_rf_we     = 1'b1;
    rf_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_rf_flush  = 1'b0;
    rf_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    uop_valid    = 1'b0;
    uop_reg      = 3'd0;
    uop_first    = 1'b0;
    uop_last     = 1'b0;

    if (state == HALTED) begin
      // Only the MEM/WB stage keeps draining; EX/MEM keeps feeding NOPs.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_rf_we     = 1'b0;
      rf_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (dmem_stall) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_rf_we  = 1'b0;
      rf_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (ex_illegal) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_rf_we     = 1'b0;
      rf_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      ex_mem_flush = 1'b1;
      state_nxt    = HALTED;
      mask_nxt     = 8'd0;
    end else if (redirect_ex) begin
      if_id_we    = 1'b0;
      id_rf_we    = 1'b0;
      rf_ex_we    = 1'b0;
      if_id_flush = 1'b1;
      id_rf_flush = 1'b1;
      rf_ex_flush = 1'b1;
      state_nxt   = RUN;
      mask_nxt    = 8'd0;
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_rf_we    = 1'b0;
      rf_ex_we    = 1'b0;
      rf_ex_flush = 1'b1;
    end else if (state == RUN && redirect_id) begin
      if_id_we    = 1'b0;
      if_id_flush = 1'b1;
    end else if (state == MULTI) begin
      uop_valid = 1'b1;
      uop_reg   = low;
      mask_nxt  = rest;
      if (rest == 8'd0) begin
        uop_last  = 1'b1;
        state_nxt = RUN;
      end else begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
      end
    end else if (id_valid && id_is_lmsm) begin
      if (id_reglist == 8'd0) begin
        // Empty list: the instruction does nothing, drop it at ID/RF.
        id_rf_we    = 1'b0;
        id_rf_flush = 1'b1;
      end else begin
        uop_valid = 1'b1;
        uop_first = 1'b1;
        uop_reg   = low;
        if (rest == 8'd0) begin
          uop_last = 1'b1;
        end else begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          mask_nxt  = rest;
          state_nxt = MULTI;
        end
      end
    end

    // Outputs are forced quiet while reset is held.
    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_rf_we     = 1'b0;
      rf_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      if_id_flush  = 1'b0;
      id_rf_flush  = 1'b0;
      rf_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      uop_valid    = 1'b0;
      uop_reg      = 3'd0;
      uop_first    = 1'b0;
      uop_last     = 1'b0;
    end
  end

  assign seq_busy = rst_n && (state == MULTI);
  assign halted   = rst_n && (state == HALTED);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the sequencer.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_is_lmsm, redirect_id, rf_ra_used, rf_rb_used;
  logic [7:0] id_reglist;
  logic [2:0] rf_ra, rf_rb, ex_rd;
  logic       ex_mem_rd, redirect_ex, ex_illegal, dmem_stall;
  logic       pc_we, if_id_we, id_rf_we, rf_ex_we, ex_mem_we, mem_wb_we;
  logic       if_id_flush, id_rf_flush, rf_ex_flush, ex_mem_flush;
  logic       uop_valid, uop_first, uop_last, seq_busy, halted;
  logic [2:0] uop_reg;

  int checks = 0;
  int errors = 0;

  // Model state: registers still to be emitted, and the halt flag.
  int q[$];
  int nq[$];
  bit mhalt, nhalt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_lmsm(id_is_lmsm),
    .id_reglist(id_reglist), .redirect_id(redirect_id), .rf_ra_used(rf_ra_used),
    .rf_rb_used(rf_rb_used), .rf_ra(rf_ra), .rf_rb(rf_rb), .ex_mem_rd(ex_mem_rd),
    .ex_rd(ex_rd), .redirect_ex(redirect_ex), .ex_illegal(ex_illegal),
    .dmem_stall(dmem_stall), .pc_we(pc_we), .if_id_we(if_id_we), .id_rf_we(id_rf_we),
    .rf_ex_we(rf_ex_we), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_rf_flush(id_rf_flush), .rf_ex_flush(rf_ex_flush),
    .ex_mem_flush(ex_mem_flush), .uop_valid(uop_valid), .uop_reg(uop_reg),
    .uop_first(uop_first), .uop_last(uop_last), .seq_busy(seq_busy), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] dut_vec();
    return {pc_we, if_id_we, id_rf_we, rf_ex_we, ex_mem_we, mem_wb_we,
            if_id_flush, id_rf_flush, rf_ex_flush, ex_mem_flush,
            uop_valid, uop_reg, uop_first, uop_last, seq_busy, halted};
  endfunction

  // frz: registers held this cycle; fl: registers loaded with a NOP.
  // Bit order for frz: pc, if_id, id_rf, rf_ex, ex_mem, mem_wb.
  // Bit order for fl: if_id, id_rf, rf_ex, ex_mem.
  task automatic ref_model(output logic [17:0] e);
    logic [5:0] frz, we;
    logic [3:0] fl;
    logic       uv, uf, ul, busy, lu;
    logic [2:0] ur;
    nq = q;
    nhalt = mhalt;
    frz = '0; fl = '0; uv = 0; uf = 0; ul = 0; ur = '0;
    busy = (q.size() > 0);
    lu = ex_mem_rd && ((rf_ra_used && rf_ra == ex_rd) || (rf_rb_used && rf_rb == ex_rd));
    if (mhalt) begin
      frz = 6'b111100; fl = 4'b0001;
    end else if (dmem_stall) begin
      frz = 6'b111111;
    end else if (ex_illegal) begin
      frz = 6'b111100; fl = 4'b0001; nhalt = 1; nq.delete();
    end else if (redirect_ex) begin
      fl = 4'b1110; nq.delete();
    end else if (lu) begin
      frz = 6'b111000; fl = 4'b0010;
    end else if (!busy && redirect_id) begin
      fl = 4'b1000;
    end else if (busy) begin
      uv = 1; ur = 3'(nq.pop_front()); ul = (nq.size() == 0);
      if (!ul) frz = 6'b110000;
    end else if (id_valid && id_is_lmsm) begin
      for (int i = 0; i < 8; i++) if (id_reglist[i]) nq.push_back(i);
      if (nq.size() == 0) fl = 4'b0100;
      else begin
        uv = 1; uf = 1; ur = 3'(nq.pop_front()); ul = (nq.size() == 0);
        if (!ul) frz = 6'b110000;
      end
    end
    we = ~frz & ~{1'b0, fl, 1'b0};
    e = {we, fl, uv, ur, uf, ul, busy, mhalt};
  endtask

  // Called just after a negedge with inputs already set; returns at the next negedge.
  task automatic step(input string tag);
    logic [17:0] e;
    #1;
    if (!rst_n) begin
      e = '0; nq.delete(); nhalt = 0;
    end else begin
      ref_model(e);
    end
    chk(tag, 32'(dut_vec()), 32'(e));
    @(posedge clk);
    q = nq;
    mhalt = nhalt;
    @(negedge clk);
  endtask

  task automatic idle_in();
    id_valid = 0; id_is_lmsm = 0; id_reglist = '0; redirect_id = 0;
    rf_ra_used = 0; rf_rb_used = 0; rf_ra = '0; rf_rb = '0;
    ex_mem_rd = 0; ex_rd = '0; redirect_ex = 0; ex_illegal = 0; dmem_stall = 0;
  endtask

  task automatic areset();
    #2 rst_n = 0;
    #1 chk("arst_out", 32'(dut_vec()), 32'd0);
    q.delete();
    mhalt = 0;
    @(negedge clk);
    step("rst_hold");
    rst_n = 1;
  endtask

  task automatic lm_a4();
    id_valid = 1; id_is_lmsm = 1; id_reglist = 8'b1010_0100;
  endtask

  initial begin
    idle_in();
    @(negedge clk);
    step("reset");
    rst_n = 1;
    #1 chk("idle_we", {pc_we, if_id_we, id_rf_we, rf_ex_we, ex_mem_we, mem_wb_we}, 6'h3f);
    step("idle");

    // Load-use bubble, then rb match ignored when rb unused.
    ex_mem_rd = 1; ex_rd = 3; rf_ra_used = 1; rf_ra = 3;
    #1 chk("lu_flush", {pc_we, if_id_we, id_rf_we, rf_ex_flush}, 4'b0001);
    step("lu");
    rf_ra_used = 0; rf_rb = 3; rf_rb_used = 0;
    step("lu_rb_unused");
    idle_in();

    // LM 1010_0100: regs 2,5,7.
    lm_a4();
    #1 chk("lm_c1", {uop_reg, uop_first, uop_last, pc_we, seq_busy}, {3'd2, 4'b1000});
    step("lm1");
    idle_in();
    #1 chk("lm_c2", {uop_reg, uop_first, uop_last, pc_we, seq_busy}, {3'd5, 4'b0001});
    step("lm2");
    #1 chk("lm_c3", {uop_reg, uop_first, uop_last, pc_we, seq_busy}, {3'd7, 4'b0111});
    step("lm3");
    step("lm_done");

    // Same LM, dmem_stall on cycle 2.
    lm_a4(); step("lms1");
    idle_in(); dmem_stall = 1;
    #1 chk("lms_frozen", {pc_we, if_id_we, id_rf_we, rf_ex_we, ex_mem_we, mem_wb_we}, 6'h00);
    step("lms2");
    dmem_stall = 0;
    #1 chk("lms_r5", uop_reg, 3'd5);
    step("lms3"); step("lms4"); step("lms5");

    // Same LM, redirect_ex on cycle 2 aborts the sequence.
    lm_a4(); step("lmr1");
    idle_in(); redirect_ex = 1;
    step("lmr2");
    redirect_ex = 0;
    #1 chk("lmr_abort", {uop_valid, seq_busy}, 2'b00);
    step("lmr3");

    // Priority: redirect_ex over load_use and redirect_id.
    redirect_ex = 1; redirect_id = 1; ex_mem_rd = 1; ex_rd = 2; rf_rb_used = 1; rf_rb = 2;
    step("prio_rex");
    idle_in();
    dmem_stall = 1; redirect_ex = 1; step("stall_rex1"); step("stall_rex2");
    dmem_stall = 0;
    #1 chk("rex_after_stall", {if_id_flush, id_rf_flush, rf_ex_flush}, 3'b111);
    step("rex_apply");
    idle_in();

    // Empty and single-bit register lists, redirect_id in MULTI ignored.
    id_valid = 1; id_is_lmsm = 1; id_reglist = 8'h00; step("lm_empty");
    id_reglist = 8'h40; step("lm_single");
    id_reglist = 8'h81; step("lm_two");
    idle_in(); redirect_id = 1; step("rid_in_multi");
    step("rid_run");
    idle_in();

    // Async reset mid-MULTI.
    lm_a4(); step("lmx1");
    idle_in(); areset();
    step("post_rst");

    // Illegal instruction halts until reset.
    ex_illegal = 1;
    #1 chk("ill_flush", {ex_mem_flush, mem_wb_we, pc_we}, 3'b110);
    step("ill");
    ex_illegal = 0; redirect_ex = 1; step("halt1");
    idle_in(); lm_a4(); step("halt2");
    #1 chk("halted", halted, 1'b1);
    idle_in(); step("halt3");
    areset();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      dmem_stall  = ($urandom_range(0, 9) == 0);
      ex_illegal  = ($urandom_range(0, 199) == 0);
      redirect_ex = ($urandom_range(0, 11) == 0);
      redirect_id = ($urandom_range(0, 9) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_is_lmsm  = ($urandom_range(0, 2) == 0);
      id_reglist  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      ex_mem_rd   = $urandom_range(0, 1);
      ex_rd       = 3'($urandom_range(0, 3));
      rf_ra       = 3'($urandom_range(0, 3));
      rf_rb       = 3'($urandom_range(0, 3));
      rf_ra_used  = $urandom_range(0, 1);
      rf_rb_used  = $urandom_range(0, 1);
      if ($urandom_range(0, 299) == 0 || (mhalt && $urandom_range(0, 9) == 0)) areset();
      else step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
